// File: rtl/crc8_table.sv
// CRC-8 (poly 0x07, MSB-first, init 0x00) byte lookup table with a one-cycle registered read port.
// The table is generated by a constant function, so it is valid from time zero regardless of reset.
module crc8_table (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] crcTable [0:255],
   input  logic [7:0] lut_idx,
   input  logic       lut_req,
   output logic [7:0] lut_data,
   output logic       lut_vld
);

   // Remainder of idx * x^8 mod (x^8 + x^2 + x + 1).
   function automatic logic [7:0] crc8_entry(input logic [7:0] idx);
      logic [7:0] r;
      r = idx;
      for (int k = 0; k < 8; k++) begin
         r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
      end
      return r;
   endfunction

   for (genvar gi = 0; gi < 256; gi++) begin : g_tab
      assign crcTable[gi] = crc8_entry(8'(gi));
   end

   logic [7:0] lut_data_d, lut_data_q;
   logic       lut_vld_d, lut_vld_q;

   always_comb begin
      lut_data_d = lut_data_q;
      lut_vld_d  = lut_req;
      if (lut_req) begin
         lut_data_d = crcTable[lut_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lut_data_q <= 8'h00;
         lut_vld_q  <= 1'b0;
      end else begin
         lut_data_q <= lut_data_d;
         lut_vld_q  <= lut_vld_d;
      end
   end

   assign lut_data = lut_data_q;
   assign lut_vld  = lut_vld_q;

endmodule

// File: tb/tb_crc8_table.sv
// Self-checking bench for crc8_table: table sweep against a polynomial-division model,
// CRC folding properties, and the registered lookup port including asynchronous reset.
module tb_crc8_table;

   logic       clk;
   logic       reset;
   logic [7:0] tab [0:255];
   logic [7:0] lut_idx;
   logic       lut_req;
   logic [7:0] lut_data;
   logic       lut_vld;

   int checks = 0;
   int errors = 0;

   crc8_table dut (
      .clk      (clk),
      .reset    (reset),
      .crcTable (tab),
      .lut_idx  (lut_idx),
      .lut_req  (lut_req),
      .lut_data (lut_data),
      .lut_vld  (lut_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Long division of (v * x^8) by 0x107 over GF(2).
   function automatic logic [7:0] ref_crc(input logic [7:0] v);
      logic [15:0] r;
      r = {v, 8'h00};
      for (int b = 15; b >= 8; b--) begin
         if (r[b]) r = r ^ (16'h0107 << (b - 8));
      end
      return r[7:0];
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected registered-port state, derived from request history.
   logic [7:0] exp_data;
   logic       exp_vld;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_data <= 8'h00;
         exp_vld  <= 1'b0;
      end else begin
         exp_vld <= lut_req;
         if (lut_req) exp_data <= ref_crc(lut_idx);
      end
   end

   always @(negedge clk) begin
      check8("port_vld", {7'd0, lut_vld}, {7'd0, exp_vld});
      check8("port_data", lut_data, exp_data);
   end

   logic [7:0] rem;
   logic [7:0] msg [0:7];
   logic [7:0] a, b;
   logic [7:0] crc_m;
   int         zero_hits;

   initial begin
      reset   = 1'b1;
      lut_idx = 8'h00;
      lut_req = 1'b0;
      #1;
      check8("rst_data", lut_data, 8'h00);
      check8("rst_vld", {7'd0, lut_vld}, 8'h00);
      check8("tab_in_reset_01", tab[1], 8'h07);
      check8("tab_in_reset_ff", tab[255], 8'hF3);

      // Full sweep and anchors.
      for (int i = 0; i < 256; i++) check8($sformatf("tab[%02h]", i), tab[i], ref_crc(8'(i)));
      check8("anchor_00", tab[8'h00], 8'h00);
      check8("anchor_01", tab[8'h01], 8'h07);
      check8("anchor_02", tab[8'h02], 8'h0E);
      check8("anchor_03", tab[8'h03], 8'h09);
      check8("anchor_10", tab[8'h10], 8'h70);
      check8("anchor_80", tab[8'h80], 8'h89);
      check8("anchor_fc", tab[8'hFC], 8'hFA);
      check8("anchor_fd", tab[8'hFD], 8'hFD);
      check8("anchor_fe", tab[8'hFE], 8'hF4);
      check8("anchor_ff", tab[8'hFF], 8'hF3);
      check8("model_pin_80", ref_crc(8'h80), 8'h89);

      // "123456789" check value, then appending it folds to zero.
      rem = 8'h00;
      for (int i = 0; i < 9; i++) rem = tab[8'(8'h31 + i) ^ rem];
      check8("check_123456789", rem, 8'hF4);
      rem = tab[8'hF4 ^ rem];
      check8("check_append", rem, 8'h00);

      // Linearity over GF(2).
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         check8("linearity", tab[a ^ b], tab[a] ^ tab[b]);
      end

      // Seven-byte message plus CRC; single-bit flips must not fold to zero.
      crc_m = 8'h00;
      for (int i = 0; i < 7; i++) begin
         msg[i] = 8'(i);
         crc_m  = ref_crc(8'(i) ^ crc_m);
      end
      msg[7] = crc_m;
      rem = 8'h00;
      for (int i = 0; i < 8; i++) rem = tab[msg[i] ^ rem];
      check8("msg_crc_zero", rem, 8'h00);
      zero_hits = 0;
      for (int bit_pos = 0; bit_pos < 64; bit_pos++) begin
         rem = 8'h00;
         for (int i = 0; i < 8; i++) begin
            rem = tab[(msg[i] ^ ((i == bit_pos / 8) ? 8'(1 << (bit_pos % 8)) : 8'h00)) ^ rem];
         end
         if (rem == 8'h00) zero_hits++;
      end
      check8("bitflip_zero_hits", 8'(zero_hits), 8'h00);

      // Release reset and exercise the registered port.
      @(posedge clk); #2;
      reset = 1'b0;
      @(posedge clk); #2;
      check8("idle_vld", {7'd0, lut_vld}, 8'h00);
      lut_req = 1'b1;
      lut_idx = 8'h01;
      @(posedge clk); #2;
      check8("b2b_data_01", lut_data, 8'h07);
      check8("b2b_vld_01", {7'd0, lut_vld}, 8'h01);
      lut_idx = 8'h80;
      @(posedge clk); #2;
      check8("b2b_data_80", lut_data, 8'h89);
      check8("b2b_vld_80", {7'd0, lut_vld}, 8'h01);
      lut_idx = 8'hFF;
      @(posedge clk); #2;
      check8("b2b_data_ff", lut_data, 8'hF3);
      check8("b2b_vld_ff", {7'd0, lut_vld}, 8'h01);
      lut_req = 1'b0;
      lut_idx = 8'h10;
      @(posedge clk); #2;
      check8("hold_data", lut_data, 8'hF3);
      check8("hold_vld", {7'd0, lut_vld}, 8'h00);

      // Random back-to-back traffic, checked by the compare process.
      for (int i = 0; i < 40; i++) begin
         lut_req = 1'($urandom_range(0, 1));
         lut_idx = 8'($urandom_range(0, 255));
         @(posedge clk); #2;
      end

      // Mid-cycle asynchronous reset with a pending request.
      lut_req = 1'b1;
      lut_idx = 8'h03;
      @(posedge clk); #2;
      lut_idx = 8'hFE;
      #2;
      reset = 1'b1;
      #1;
      check8("async_rst_data", lut_data, 8'h00);
      check8("async_rst_vld", {7'd0, lut_vld}, 8'h00);
      for (int i = 0; i < 256; i++) check8("tab_during_rst", tab[i], ref_crc(8'(i)));
      @(posedge clk); #1;
      check8("rst_pending_discard", {7'd0, lut_vld}, 8'h00);
      #1;
      reset = 1'b0;
      @(posedge clk); #2;
      check8("first_after_rst_data", lut_data, 8'hF4);
      check8("first_after_rst_vld", {7'd0, lut_vld}, 8'h01);
      lut_req = 1'b0;
      @(posedge clk); #2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
